// File: rtl/line_clear_engine.sv
// Full-row detection and downward compaction of the placed board, one row per clock.
// Optional LINE_CLEAR_SCORE_EN adds a saturating 20-bit score accumulator.
module line_clear_engine #(
   parameter int COLS   = 10,
   parameter int ROWS   = 20,
   parameter int CELL_W = 3,
   parameter int CNT_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [ROWS*COLS*CELL_W-1:0] board_in,
   output logic                        busy,
   output logic                        done,
   output logic [ROWS*COLS*CELL_W-1:0] board_out,
   output logic [CNT_W-1:0]            lines_cleared,
`ifdef LINE_CLEAR_SCORE_EN
   output logic [19:0]                 score,
`endif
   output logic [ROWS-1:0]             full_rows
);

   localparam int ROW_W = COLS * CELL_W;
   localparam int BW    = ROWS * ROW_W;
   localparam int IDX_W = $clog2(ROWS + 1);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] NUM_ROWS = IDX_W'(ROWS);

   typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

   state_t               state_q, state_d;
   logic [ROW_W-1:0]     row_buf [ROWS];
   logic [IDX_W-1:0]     rd_q, wr_q, wr_nxt;
   logic [CNT_W-1:0]     count_q, lines_q;
   logic [BW-1:0]        board_q, buf_flat;
   logic                 row_full;

   always_comb begin
      row_full = 1'b1;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (row_buf[rd_q][c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
      end
   end

   assign wr_nxt = row_full ? wr_q : wr_q + 1'b1;

   always_comb begin
      buf_flat = '0;
      for (int unsigned r = 0; r < ROWS; r++) buf_flat[r*ROW_W +: ROW_W] = row_buf[r];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: if (rd_q == LAST_ROW) state_d = (wr_nxt < NUM_ROWS) ? FILL : DONE;
         FILL: if (wr_q == LAST_ROW) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef LINE_CLEAR_SCORE_EN
   logic [19:0] award;
   logic [20:0] score_sum;

   always_comb begin
      case (count_q)
         CNT_W'(0): award = 20'd0;
         CNT_W'(1): award = 20'd40;
         CNT_W'(2): award = 20'd100;
         CNT_W'(3): award = 20'd300;
         default:   award = 20'd1200;
      endcase
      score_sum = {1'b0, score} + {1'b0, award};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              score <= '0;
      else if (state_q == DONE) score <= score_sum[20] ? '1 : score_sum[19:0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < ROWS; r++) row_buf[r] <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
         lines_q   <= '0;
         board_q   <= '0;
         full_rows <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               for (int unsigned r = 0; r < ROWS; r++) row_buf[r] <= board_in[r*ROW_W +: ROW_W];
               rd_q      <= '0;
               wr_q      <= '0;
               count_q   <= '0;
               full_rows <= '0;
            end
            SCAN: begin
               // in-place copy is safe: wr never passes rd
               if (row_full) begin
                  full_rows[rd_q] <= 1'b1;
                  count_q         <= count_q + 1'b1;
               end else begin
                  row_buf[wr_q] <= row_buf[rd_q];
               end
               wr_q <= wr_nxt;
               if (rd_q != LAST_ROW) rd_q <= rd_q + 1'b1;
            end
            FILL: begin
               row_buf[wr_q] <= '0;
               wr_q          <= wr_q + 1'b1;
            end
            DONE: begin
               board_q <= buf_flat;
               lines_q <= count_q;
            end
            default: ;
         endcase
      end
   end

   // results come straight from the buffer during DONE, then from the held copy
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign board_out     = done ? buf_flat : board_q;
   assign lines_cleared = done ? count_q  : lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed and random board clears checked against a row-list reference model.
module tb_line_clear_engine;

   localparam int COLS   = 10;
   localparam int ROWS   = 20;
   localparam int CELL_W = 3;
   localparam int CNT_W  = 5;
   localparam int ROW_W  = COLS * CELL_W;
   localparam int BW     = ROWS * ROW_W;

   typedef logic [CELL_W-1:0] grid_t [ROWS][COLS];

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [BW-1:0]     board_in;
   logic              busy, done;
   logic [BW-1:0]     board_out;
   logic [CNT_W-1:0]  lines_cleared;
   logic [ROWS-1:0]   full_rows;
`ifdef LINE_CLEAR_SCORE_EN
   logic [19:0]       score;
   int unsigned       exp_score = 0;
`endif

   int total = 0;
   int bad   = 0;
   logic [BW-1:0]    prev_board;
   logic [CNT_W-1:0] prev_lines;

   always #5 clk = ~clk;

   line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .board_in(board_in),
      .busy(busy), .done(done), .board_out(board_out), .lines_cleared(lines_cleared),
`ifdef LINE_CLEAR_SCORE_EN
      .score(score),
`endif
      .full_rows(full_rows)
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] pack(input grid_t g);
      logic [BW-1:0] v = '0;
      for (int unsigned y = 0; y < ROWS; y++)
         for (int unsigned x = 0; x < COLS; x++)
            v[(y*COLS+x)*CELL_W +: CELL_W] = g[y][x];
      return v;
   endfunction

   function automatic grid_t empty_grid();
      grid_t g;
      for (int unsigned y = 0; y < ROWS; y++)
         for (int unsigned x = 0; x < COLS; x++) g[y][x] = '0;
      return g;
   endfunction

   // reference: keep non-full rows in bottom-up order, stack them from row 0, pad with empty rows
   task automatic model(input logic [BW-1:0] b, output logic [BW-1:0] eb, output int lines,
                        output logic [ROWS-1:0] fm);
      logic [ROW_W-1:0] kept[$];
      logic [ROW_W-1:0] row;
      bit full;
      fm = '0;
      for (int y = 0; y < ROWS; y++) begin
         row  = b[y*ROW_W +: ROW_W];
         full = 1;
         for (int x = 0; x < COLS; x++) if (row[x*CELL_W +: CELL_W] == '0) full = 0;
         if (full) fm[y] = 1'b1;
         else kept.push_back(row);
      end
      lines = ROWS - kept.size();
      eb = '0;
      foreach (kept[i]) eb[i*ROW_W +: ROW_W] = kept[i];
   endtask

   task automatic rand_grid(output grid_t g);
      for (int y = 0; y < ROWS; y++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int x = 0; x < COLS; x++) g[y][x] = CELL_W'($urandom_range(1, 7));
         end else begin
            for (int x = 0; x < COLS; x++) g[y][x] = CELL_W'($urandom_range(0, 7));
            g[y][$urandom_range(0, COLS-1)] = '0;
         end
      end
   endtask

   task automatic run_board(input logic [BW-1:0] b, input string tag,
                            input bit back_to_back, input bit second_start);
      logic [BW-1:0]   eb;
      int              el;
      logic [ROWS-1:0] efm;
      int              k;
      int              extra;
      model(b, eb, el, efm);
      if (!back_to_back) @(negedge clk);
      board_in = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      board_in = ~b;
      k = 1;
      while (done !== 1'b1 && k < 3*ROWS) begin
         if (k == 2) begin
            chk({tag, "/busy"}, BW'(busy), BW'(1));
            chk({tag, "/hold_board"}, board_out, prev_board);
            chk({tag, "/hold_lines"}, BW'(lines_cleared), BW'(prev_lines));
         end
         start = second_start && (k == 4);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({tag, "/latency"}, BW'(k), BW'(ROWS + el + 1));
      chk({tag, "/busy_at_done"}, BW'(busy), BW'(1));
      chk({tag, "/board"}, board_out, eb);
      chk({tag, "/lines"}, BW'(lines_cleared), BW'(el));
      chk({tag, "/full_rows"}, BW'(full_rows), BW'(efm));
      prev_board = eb;
      prev_lines = CNT_W'(el);
`ifdef LINE_CLEAR_SCORE_EN
      begin
         int unsigned tbl[5] = '{0, 40, 100, 300, 1200};
         exp_score = exp_score + tbl[(el > 4) ? 4 : el];
         if (exp_score > 32'hFFFFF) exp_score = 32'hFFFFF;
      end
`endif
      @(negedge clk);
      chk({tag, "/done_pulse"}, BW'(done), BW'(0));
      chk({tag, "/idle"}, BW'(busy), BW'(0));
      chk({tag, "/board_held"}, board_out, eb);
`ifdef LINE_CLEAR_SCORE_EN
      chk({tag, "/score"}, BW'(score), BW'(exp_score));
`endif
      if (second_start) begin
         extra = 0;
         repeat (2*ROWS) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
         end
         chk({tag, "/no_second_done"}, BW'(extra), BW'(0));
      end
   endtask

   initial begin
      grid_t g;
      rst_n      = 1'b0;
      start      = 1'b0;
      board_in   = '0;
      prev_board = '0;
      prev_lines = '0;
      repeat (3) @(negedge clk);
      chk("reset/busy", BW'(busy), BW'(0));
      chk("reset/done", BW'(done), BW'(0));
      chk("reset/board", board_out, '0);
      chk("reset/lines", BW'(lines_cleared), BW'(0));
      chk("reset/full_rows", BW'(full_rows), BW'(0));
      rst_n = 1'b1;

      run_board('0, "empty", 0, 0);

      g = empty_grid();
      for (int x = 0; x < COLS; x++) g[0][x] = 3'd1;
      g[1][3] = 3'd5;
      run_board(pack(g), "one_line", 0, 0);
      g = empty_grid();
      g[0][3] = 3'd5;
      chk("one_line/explicit_board", board_out, pack(g));
      chk("one_line/explicit_full", BW'(full_rows), BW'(20'h00001));

      g = empty_grid();
      for (int x = 0; x < COLS; x++) begin
         g[0][x] = 3'd1; g[2][x] = 3'd2; g[3][x] = 3'd6; g[5][x] = 3'd7;
      end
      g[1][0] = 3'd2;
      g[4][9] = 3'd7;
      run_board(pack(g), "four_lines", 1, 0);
      g = empty_grid();
      g[0][0] = 3'd2;
      g[1][9] = 3'd7;
      chk("four_lines/explicit_board", board_out, pack(g));
      chk("four_lines/explicit_full", BW'(full_rows), BW'(20'h0002D));
      chk("four_lines/explicit_lines", BW'(lines_cleared), BW'(4));

      g = empty_grid();
      for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) g[y][x] = 3'd3;
      run_board(pack(g), "all_full", 0, 0);
      chk("all_full/explicit_board", board_out, '0);

      rand_grid(g);
      for (int y = 0; y < ROWS-1; y++) g[y][0] = '0;
      for (int x = 0; x < COLS; x++) g[ROWS-1][x] = 3'd4;
      run_board(pack(g), "top_only", 0, 0);

      rand_grid(g);
      run_board(pack(g), "double_start", 0, 1);

      for (int i = 0; i < 24; i++) begin
         rand_grid(g);
         run_board(pack(g), $sformatf("rand%0d", i), (i % 2) == 1, 0);
      end

      // abort mid-SCAN with an asynchronous reset
      rand_grid(g);
      @(negedge clk);
      board_in = pack(g);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort/busy", BW'(busy), BW'(0));
      chk("abort/done", BW'(done), BW'(0));
      chk("abort/board", board_out, '0);
      chk("abort/lines", BW'(lines_cleared), BW'(0));
`ifdef LINE_CLEAR_SCORE_EN
      chk("abort/score", BW'(score), BW'(0));
      exp_score = 0;
`endif
      repeat (3) begin
         @(negedge clk);
         chk("abort/no_done", BW'(done), BW'(0));
      end
      rst_n      = 1'b1;
      prev_board = '0;
      prev_lines = '0;

      rand_grid(g);
      run_board(pack(g), "after_abort", 0, 0);

`ifdef LINE_CLEAR_SCORE_EN
      rst_n = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      exp_score  = 0;
      prev_board = '0;
      prev_lines = '0;
      g = empty_grid();
      for (int x = 0; x < COLS; x++) g[0][x] = 3'd1;
      run_board(pack(g), "score1", 0, 0);
      chk("score1/explicit", BW'(score), BW'(40));
      g = empty_grid();
      for (int y = 0; y < 4; y++) for (int x = 0; x < COLS; x++) g[y][x] = 3'd2;
      run_board(pack(g), "score4", 1, 0);
      chk("score4/explicit", BW'(score), BW'(1240));
      g = empty_grid();
      for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) g[y][x] = 3'd6;
      for (int i = 0; i < 875; i++) run_board(pack(g), "score_sat", 1, 0);
      chk("score_sat/explicit", BW'(score), BW'(20'hFFFFF));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Back end of the brick-placement path: brick placement writes cells into the placed-board register, and this block reads that board back.
- It finds full rows, removes them and compacts the remaining rows downward, one row per clock.
- It returns the compacted board with a cleared-line count and a full-row mask.
- The game FSM starts it after every PLACE and waits for done before spawning the next brick.

Parameters:
- COLS, 10, board width in cells.
- ROWS, 20, board height in cells.
- CELL_W, 3, bits per cell. 0 = empty; 1..7 = brick type.
- CNT_W, 5, width of lines_cleared. Must satisfy 2^CNT_W > ROWS.

Ports:
- clk  input  1  main game clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; board_in is sampled on this edge.
- board_in  input  ROWS*COLS*CELL_W  placed board. Cell (x,y) occupies bits [(y*COLS+x)*CELL_W +: CELL_W]; y=0 is the bottom row.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- board_out  output  ROWS*COLS*CELL_W  compacted board, same layout as board_in; held until the next accepted start.
- lines_cleared  output  CNT_W  number of full rows removed.
- full_rows  output  ROWS  bit y set if row y of the sampled board_in was full.

Behaviour:
- Reset (async, rst_n=0): state IDLE; internal buffer, board_out, lines_cleared, full_rows cleared to 0; busy=0, done=0. Reset asserted mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, SCAN, FILL, DONE.
- IDLE:
  - start=1: copy board_in into buffer; rd=0, wr=0; cleared count=0; full_rows=0; go to SCAN.
  - start=0: stay in IDLE; outputs hold.
- SCAN (one row per cycle, row rd):
  - Row is full when every cell is nonzero. Then set full_rows[rd], count+1, wr unchanged.
  - Otherwise copy buffer row rd to row wr, then wr+1. The copy is in place; wr<=rd always, so no data is lost.
  - When rd=ROWS-1 the row is still processed, then go to FILL if wr<ROWS, else go to DONE.
  - Otherwise rd+1.
- FILL: zero buffer row wr, then wr+1. When wr=ROWS-1 the row is zeroed, then go to DONE.
- DONE: done=1 for exactly one cycle; board_out=buffer; lines_cleared=count; go to IDLE.
- Latency: start at edge T0 gives done high in the cycle after edge T0+ROWS+lines_cleared. That is ROWS+lines_cleared+1 cycles of busy.
- start while busy or in DONE is ignored. No queuing.
- start in IDLE directly after DONE is accepted. board_out keeps the previous result until the new DONE.
- Boundary cases:
  - Empty board: lines_cleared=0, board_out=board_in, no FILL cycles.
  - All rows full: lines_cleared=ROWS, board_out all zero, FILL covers rows 0..ROWS-1.
  - Only top row full: the top row is zeroed and the rest is unchanged.
  - Cell values are preserved bit-exact when moved.

Optional Feature:
- Macro LINE_CLEAR_SCORE_EN.
- Defined:
  - Extra output score, 20 bits, cleared on reset only.
  - On the DONE cycle, add an award based on lines_cleared: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - Addition saturates at 20'hFFFFF.
  - The updated score is visible the cycle after done.
- Undefined: no score port, no adder logic.

Test Plan:
- Empty board, start -> done 21 cycles after start; lines_cleared=0; full_rows=0; board_out=0.
- Row 0 all type 1, row 1 holds only cell (3,1)=5, start -> lines_cleared=1; full_rows=20'h00001; board_out has only (3,0)=5; done 22 cycles after start.
- Rows 0,2,3,5 full, row 1 = {(0,1)=2}, row 4 = {(9,4)=7}, start -> lines_cleared=4; full_rows=20'h0002D; board_out: (0,0)=2, (9,1)=7, all other cells 0.
- All 200 cells = 3 -> lines_cleared=20; board_out=0; done 41 cycles after start.
- Second start pulse during busy -> ignored, single done pulse. rst_n pulled low mid-SCAN -> busy=0 at once, no done, board_out=0.
- LINE_CLEAR_SCORE_EN: clears of 1 then 4 lines -> score 40 then 1240. Preload score near 20'hFFFFF -> score saturates at 20'hFFFFF.
